// File: rtl/axi_serial_pkg.sv
// Shared definitions for the axi_tx / axi_rx serial link: default word width,
// transmitter FSM states and the parity helper used on both ends.
package axi_serial_pkg;

  localparam int unsigned DEFAULT_PACKET_LENGTH = 32;
  localparam int unsigned MAX_PACKET_LENGTH     = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    GAP    = 2'd2,
    PARITY = 2'd3
  } tx_state_e;

  // Callers zero-extend narrower words; the extra zeros do not change the XOR.
  function automatic logic even_parity(input logic [MAX_PACKET_LENGTH-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/axi_sclk_gen.sv
// Serial clock divider: sclk toggles every CLK_DIV aclk cycles, idle-low after
// reset; rise_evt/fall_evt flag the aclk cycle whose closing edge moves sclk.
module axi_sclk_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic aclk,
  input  logic areset,
  output logic sclk,
  output logic rise_evt,
  output logic fall_evt
);

  localparam int unsigned   CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          wrap;

  always_comb begin
    wrap   = (cnt_q == CNT_MAX);
    cnt_d  = wrap ? '0 : cnt_q + CW'(1);
    sclk_d = wrap ? ~sclk_q : sclk_q;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk     = sclk_q;
  assign rise_evt = wrap && !sclk_q;
  assign fall_evt = wrap && sclk_q;

endmodule

// File: rtl/axi_tx.sv
// Parallel-to-serial transmitter: one-word hold register, MSB-first shifter,
// data updated on sclk falling edges. Define AXI_TX_PARITY_EN for a parity bit.
module axi_tx
  import axi_serial_pkg::*;
#(
  parameter int unsigned packet_length = DEFAULT_PACKET_LENGTH,
  parameter int unsigned CLK_DIV       = 2
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [packet_length-1:0] s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic                     sclk,
  output logic                     sdata,
  output logic                     svalid,
  output logic                     busy
);

  localparam int unsigned   BW       = (packet_length > 1) ? $clog2(packet_length) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(packet_length - 1);

  tx_state_e                state_q, state_d;
  logic [packet_length-1:0] hold_q, hold_d;
  logic [packet_length-1:0] shift_q, shift_d;
  logic                     hold_full_q, hold_full_d;
  logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
  logic                     sdata_q, sdata_d;
  logic                     svalid_q, svalid_d;
  logic                     fall_evt;
  logic                     load;
`ifdef AXI_TX_PARITY_EN
  logic                     parity_q, parity_d;
`endif

  axi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .aclk     (aclk),
    .areset   (areset),
    .sclk     (sclk),
    .rise_evt (),
    .fall_evt (fall_evt)
  );

  // Accepting and loading never coincide: s_ready is low whenever hold is full.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    shift_d     = shift_q;
    hold_full_d = hold_full_q;
    bit_cnt_d   = bit_cnt_q;
    sdata_d     = sdata_q;
    svalid_d    = svalid_q;
`ifdef AXI_TX_PARITY_EN
    parity_d    = parity_q;
`endif
    load = fall_evt && hold_full_q && (state_q == IDLE || state_q == GAP);

    if (s_valid && s_ready) begin
      hold_d      = s_data;
      hold_full_d = 1'b1;
    end

    if (load) begin
      hold_full_d = 1'b0;
      shift_d     = hold_q;
      sdata_d     = hold_q[packet_length-1];
      svalid_d    = 1'b1;
      bit_cnt_d   = LAST_BIT;
      state_d     = SHIFT;
`ifdef AXI_TX_PARITY_EN
      parity_d    = even_parity(MAX_PACKET_LENGTH'(hold_q));
`endif
    end else if (fall_evt) begin
      case (state_q)
        SHIFT: begin
          if (bit_cnt_q == '0) begin
`ifdef AXI_TX_PARITY_EN
            state_d  = PARITY;
            sdata_d  = parity_q;
`else
            state_d  = GAP;
            svalid_d = 1'b0;
            sdata_d  = 1'b0;
`endif
          end else begin
            shift_d   = shift_q << 1;
            sdata_d   = shift_d[packet_length-1];
            bit_cnt_d = bit_cnt_q - BW'(1);
          end
        end
`ifdef AXI_TX_PARITY_EN
        PARITY: begin
          state_d  = GAP;
          svalid_d = 1'b0;
          sdata_d  = 1'b0;
        end
`endif
        GAP:     state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      shift_q     <= '0;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      sdata_q     <= 1'b0;
      svalid_q    <= 1'b0;
`ifdef AXI_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      shift_q     <= shift_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      sdata_q     <= sdata_d;
      svalid_q    <= svalid_d;
`ifdef AXI_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign s_ready = !areset && !hold_full_q;
  assign sdata   = sdata_q;
  assign svalid  = svalid_q;
  assign busy    = (state_q != IDLE) || hold_full_q;

endmodule

// File: tb/tb_axi_tx.sv
// Scoreboard bench for axi_tx: accepted words are queued as expected frames and
// a monitor reassembles frames sampled on sclk rising edges.
module tb_axi_tx;

  localparam int unsigned PL      = 32;
  localparam int unsigned DIV     = 2;
  localparam int unsigned TIMEOUT = 2000;
`ifdef AXI_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = PL + 1;
`else
  localparam int unsigned FRAME_BITS = PL;
`endif

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [PL-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready, sclk, sdata, svalid, busy;

  int checks = 0;
  int errors = 0;

  logic [PL-1:0] expectedQ[$];
  logic [63:0]   rxBits = '0;
  int            bitCount = 0;
  int            highCycles = 0;
  int            lowCycles = 0;
  int            lastGap = 0;
  int            framesRx = 0;
  logic          inFrame = 1'b0;
  logic          sclkPrev = 1'b0;
  logic          acceptSvalid = 1'b0;

  axi_tx #(
    .packet_length (PL),
    .CLK_DIV       (DIV)
  ) dut (
    .aclk    (aclk),
    .areset  (areset),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .sclk    (sclk),
    .sdata   (sdata),
    .svalid  (svalid),
    .busy    (busy)
  );

  always #5 aclk = ~aclk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference frame: the word MSB first, optionally followed by its even parity.
  function automatic logic [63:0] frameOf(input logic [PL-1:0] w);
`ifdef AXI_TX_PARITY_EN
    return {31'd0, w, ^w};
`else
    return {32'd0, w};
`endif
  endfunction

  // Called at a negedge; holds s_valid/s_data until the handshake completes.
  task automatic applyStimulus(input logic [PL-1:0] word);
    int waitCycles = 0;
    s_data  = word;
    s_valid = 1'b1;
    while (!s_ready && waitCycles < TIMEOUT) begin
      @(negedge aclk);
      waitCycles++;
    end
    if (!s_ready) begin
      checkOutput("handshake timeout", 64'(s_ready), 64'd1);
      s_valid = 1'b0;
      return;
    end
    acceptSvalid = svalid;
    expectedQ.push_back(word);
    @(negedge aclk);
    s_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int waitCycles = 0;
    while (busy && waitCycles < TIMEOUT) begin
      @(negedge aclk);
      waitCycles++;
    end
    checkOutput("idle reached", 64'(busy), 64'd0);
    checkOutput("queue drained", 64'(expectedQ.size()), 64'd0);
  endtask

  task automatic checkFrame();
    logic [PL-1:0] word;
    framesRx++;
    if (expectedQ.size() == 0) begin
      checkOutput("unexpected frame", rxBits, 64'd0);
      return;
    end
    word = expectedQ.pop_front();
    checkOutput("frame bits", 64'(bitCount), 64'(FRAME_BITS));
    checkOutput("frame data", rxBits, frameOf(word));
    checkOutput("svalid width", 64'(highCycles), 64'(FRAME_BITS * 2 * DIV));
  endtask

  // Monitor: sample away from the active edge, collect a bit on each sclk rise.
  always @(negedge aclk) begin
    if (areset) begin
      inFrame    = 1'b0;
      bitCount   = 0;
      highCycles = 0;
      lowCycles  = 0;
      sclkPrev   = 1'b0;
    end else begin
      if (svalid) begin
        if (!inFrame) begin
          inFrame    = 1'b1;
          lastGap    = lowCycles;
          highCycles = 0;
          bitCount   = 0;
          rxBits     = '0;
        end
        highCycles++;
      end else begin
        if (inFrame) begin
          inFrame = 1'b0;
          checkFrame();
          lowCycles = 0;
        end
        lowCycles++;
      end
      if (sclk && !sclkPrev && svalid) begin
        rxBits = {rxBits[62:0], sdata};
        bitCount++;
      end
      sclkPrev = sclk;
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int startFrames;
    logic [PL-1:0] words[3];

    // Reset hold
    repeat (5) @(negedge aclk);
    checkOutput("reset sclk", 64'(sclk), 64'd0);
    checkOutput("reset sdata", 64'(sdata), 64'd0);
    checkOutput("reset svalid", 64'(svalid), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset s_ready", 64'(s_ready), 64'd0);
    areset = 1'b0;
    @(negedge aclk);
    checkOutput("s_ready after release", 64'(s_ready), 64'd1);
    checkOutput("sclk before first toggle", 64'(sclk), 64'd0);
    @(negedge aclk);
    checkOutput("first toggle is rise", 64'(sclk), 64'd1);

    // Single word and post-frame GAP length
    $display("[TB] single word");
    applyStimulus(32'hA5C30F01);
    n = 0;
    while (!svalid && n < TIMEOUT) begin @(negedge aclk); n++; end
    n = 0;
    while (svalid && n < TIMEOUT) begin @(negedge aclk); n++; end
    n = 0;
    while (busy && n < TIMEOUT) begin @(negedge aclk); n++; end
    checkOutput("busy after gap", 64'(n), 64'(2 * DIV));
    waitIdle();

    // Back-to-back words
    $display("[TB] back-to-back");
    applyStimulus(32'h12345678);
    applyStimulus(32'h9ABCDEF0);
    checkOutput("second accepted mid-frame", 64'(acceptSvalid), 64'd1);
    checkOutput("s_ready low while held", 64'(s_ready), 64'd0);
    waitIdle();
    checkOutput("inter-frame gap", 64'(lastGap), 64'(2 * DIV));

    // Burst with s_valid held high
    $display("[TB] burst");
    startFrames = framesRx;
    words[0] = 32'h00000001;
    words[1] = 32'h80000000;
    words[2] = 32'hFFFFFFFF;
    foreach (words[i]) applyStimulus(words[i]);
    waitIdle();
    checkOutput("burst frame count", 64'(framesRx - startFrames), 64'd3);

    // Reset in the middle of a frame
    $display("[TB] reset mid-frame");
    applyStimulus(32'hFFFFFFFF);
    n = 0;
    while (bitCount < 10 && n < TIMEOUT) begin @(posedge aclk); n++; end
    checkOutput("reached ten bits", 64'(bitCount >= 10), 64'd1);
    #2;
    areset = 1'b1;
    #1;
    checkOutput("async svalid clear", 64'(svalid), 64'd0);
    checkOutput("async sdata clear", 64'(sdata), 64'd0);
    checkOutput("async busy clear", 64'(busy), 64'd0);
    expectedQ.delete();
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    startFrames = framesRx;
    applyStimulus(32'h0000000F);
    waitIdle();
    checkOutput("post-reset frame count", 64'(framesRx - startFrames), 64'd1);

    // Parity-relevant words (plain frames when parity is disabled)
    applyStimulus(32'h00000007);
    applyStimulus(32'h00000003);
    waitIdle();

    // Random words with random idle spacing
    $display("[TB] random");
    startFrames = framesRx;
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 20)) @(negedge aclk);
      applyStimulus($urandom);
    end
    waitIdle();
    checkOutput("random frame count", 64'(framesRx - startFrames), 64'd10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
